// File: rtl/ysyx_25020037_rd_arbiter.sv
// ysyx_25020037_rd_arbiter
//   Shares one AXI4-Lite read port between the IFU and the LSU, one
//   outstanding read at a time. Simultaneous requests alternate
//   round-robin; all other conflicts are served in arrival order.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   ifu_ar*/ifu_r*           IFU read master (slave side of this block)
//   lsu_ar*/lsu_r*           LSU read master (slave side of this block)
//   m_ar*/m_r*               shared read port towards memory / SoC
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a grant left open for TIMEOUT_CYCLES cycles is closed
//   with a DECERR response to its master; a response the slave still
//   owes is then drained and discarded before the next grant.
//
// State    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no grant; requests sampled and arbitrated here
// GNT_IFU  | IFU owns the port (AR phase until ar_done, then R phase)
// GNT_LSU  | LSU owns the port (AR phase until ar_done, then R phase)
// ERR      | (ARB_TIMEOUT_EN) timed-out master gets DECERR until rready

module ysyx_25020037_rd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] ifu_araddr,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,

  input  logic [31:0] lsu_araddr,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,

  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_IFU = 2'd1, GNT_LSU = 2'd2, ERR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_IFU = 2'd1, GNT_LSU = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic        last_lsu_q, last_lsu_d;   // 1: LSU was the last master served
  logic        ar_done_q, ar_done_d;

  logic        sel_lsu;
  logic [31:0] req_araddr;
  logic        req_arvalid;
  logic        req_rready;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        drain_q, drain_d;
`else
  // The timeout length has no meaning without the timeout logic.
  logic [7:0]  unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_lsu_q <= 1'b0;
      ar_done_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q <= 8'd0;
      drain_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_lsu_q <= last_lsu_d;
      ar_done_q  <= ar_done_d;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      drain_q    <= drain_d;
`endif
    end
  end

  assign sel_lsu     = (state_q == GNT_LSU);
  assign req_araddr  = sel_lsu ? lsu_araddr  : ifu_araddr;
  assign req_arvalid = sel_lsu ? lsu_arvalid : ifu_arvalid;
  assign req_rready  = sel_lsu ? lsu_rready  : ifu_rready;

  always_comb begin
    state_d     = state_q;
    last_lsu_d  = last_lsu_q;
    ar_done_d   = ar_done_q;
    m_araddr    = 32'd0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = 32'd0;
    ifu_rresp   = 2'b00;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = 32'd0;
    lsu_rresp   = 2'b00;
    lsu_rvalid  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    drain_d     = drain_q;
    // The beat owed by a timed-out read is swallowed here; it never
    // reaches either master.
    if (drain_q) begin
      m_rready = 1'b1;
      if (m_rvalid) drain_d = 1'b0;
    end
`endif

    case (state_q)
      IDLE: begin
`ifdef ARB_TIMEOUT_EN
        wait_cnt_d = 8'd0;
        if (!drain_q) begin
`else
        begin
`endif
          if (ifu_arvalid && lsu_arvalid)
            state_d = last_lsu_q ? GNT_IFU : GNT_LSU;
          else if (ifu_arvalid)
            state_d = GNT_IFU;
          else if (lsu_arvalid)
            state_d = GNT_LSU;
        end
      end

      GNT_IFU, GNT_LSU: begin
        if (!ar_done_q) begin
          m_araddr  = req_araddr;
          m_arvalid = req_arvalid;
          if (sel_lsu) lsu_arready = m_arready;
          else         ifu_arready = m_arready;
          // A master withdrawing its request before the address was taken
          // simply loses the grant; it does not count as having been served.
          if (!req_arvalid)
            state_d = IDLE;
          else if (m_arready)
            ar_done_d = 1'b1;
        end else begin
          m_rready = req_rready;
          if (sel_lsu) begin
            lsu_rvalid = m_rvalid;
            lsu_rdata  = m_rdata;
            lsu_rresp  = m_rresp;
          end else begin
            ifu_rvalid = m_rvalid;
            ifu_rdata  = m_rdata;
            ifu_rresp  = m_rresp;
          end
          if (m_rvalid && req_rready) begin
            state_d    = IDLE;
            last_lsu_d = sel_lsu;
            ar_done_d  = 1'b0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (state_d != IDLE && wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d    = ERR;
          // last_grant is updated on entry so ERR can use it to know
          // which master owns the error response.
          last_lsu_d = sel_lsu;
          ar_done_d  = 1'b0;
          drain_d    = ar_done_q | (m_arvalid & m_arready);
        end
`endif
      end

`ifdef ARB_TIMEOUT_EN
      ERR: begin
        if (last_lsu_q) begin
          lsu_rvalid = 1'b1;
          lsu_rresp  = 2'b11;
          if (lsu_rready) state_d = IDLE;
        end else begin
          ifu_rvalid = 1'b1;
          ifu_rresp  = 2'b11;
          if (ifu_rready) state_d = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

endmodule
